// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - reaction-timer round sequencer
// Arms on a key press, waits a pseudo-random delay, lights the bar and times the player in ms.
module reaction_round_ctrl #(
   parameter int          CLK_PER_MS   = 50000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          TIMEOUT_MS   = 9999,
   parameter logic [11:0] LFSR_SEED    = 12'hACE
) (
   input  logic        cin,
   input  logic        reset,
   input  logic        enable,
   input  logic        key_n,
   output logic [9:0]  lights,
   output logic [23:0] reaction_ms,
   output logic [23:0] highscore,
   output logic        result_valid,
   output logic        false_start,
   output logic        timed_out,
   output logic        busy
);

   localparam int          PW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [23:0] TIMEOUT_V = 24'(TIMEOUT_MS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_LIGHT,
      S_RESULT,
      S_FALSE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_key_s1;
   logic          r_key_s2;
   logic          r_key_prev;
   logic          w_press;
   logic [11:0]   r_lfsr;
   logic          w_lfsr_fb;
   logic [PW-1:0] r_presc;
   logic          w_tick;
   logic [12:0]   r_delay;
   logic [12:0]   w_delay_nxt;
   logic [23:0]   r_react;
   logic [23:0]   w_react_nxt;
   logic [23:0]   w_react_inc;
   logic [23:0]   r_hs;
   logic [23:0]   w_hs_nxt;
   logic          r_to;
   logic          w_to_nxt;

   assign w_press     = r_key_prev & ~r_key_s2;
   assign w_lfsr_fb   = r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0];
   assign w_tick      = (r_presc == PW'(CLK_PER_MS - 1));
   assign w_react_inc = (w_tick && (r_react < TIMEOUT_V)) ? r_react + 24'd1 : r_react;

   // Synchroniser idles high so reset release never looks like a press.
   always_ff @(posedge cin or posedge reset) begin
      if (reset) begin
         r_key_s1   <= 1'b1;
         r_key_s2   <= 1'b1;
         r_key_prev <= 1'b1;
         r_lfsr     <= LFSR_SEED;
      end else begin
         r_key_s1   <= key_n;
         r_key_s2   <= r_key_s1;
         r_key_prev <= r_key_s2;
         r_lfsr     <= {r_lfsr[10:0], w_lfsr_fb};
      end
   end

   always_ff @(posedge cin or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_delay <= '0;
         r_react <= '0;
         r_hs    <= 24'hFFFFFF;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_delay <= w_delay_nxt;
         r_react <= w_react_nxt;
         r_hs    <= w_hs_nxt;
         r_to    <= w_to_nxt;
         if ((w_state_nxt != r_state) || w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_delay_nxt = r_delay;
      w_react_nxt = r_react;
      w_hs_nxt    = r_hs;
      w_to_nxt    = r_to;
      if (!enable) begin
         w_state_nxt = S_IDLE;
         w_to_nxt    = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_press) begin
                  w_state_nxt = S_ARMED;
                  w_delay_nxt = 13'(MIN_DELAY_MS) + {1'b0, r_lfsr};
                  w_react_nxt = '0;
                  w_to_nxt    = 1'b0;
               end
            end
            S_ARMED: begin
               if (w_press) begin
                  w_state_nxt = S_FALSE;
                  w_react_nxt = '0;
               end else if (w_tick) begin
                  w_delay_nxt = r_delay - 13'd1;
                  if (r_delay == 13'd1) begin
                     w_state_nxt = S_LIGHT;
                  end
               end
            end
            S_LIGHT: begin
               // Timeout is judged on the post-increment count, ahead of a coincident press.
               w_react_nxt = w_react_inc;
               if (w_tick && (w_react_inc == TIMEOUT_V)) begin
                  w_state_nxt = S_RESULT;
                  w_to_nxt    = 1'b1;
               end else if (w_press) begin
                  w_state_nxt = S_RESULT;
                  w_to_nxt    = 1'b0;
                  if (w_react_inc < r_hs) begin
                     w_hs_nxt = w_react_inc;
                  end
               end
            end
            S_RESULT: begin
               if (w_press) begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_FALSE: begin
               w_react_nxt = '0;
               if (w_press) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign lights       = (r_state == S_LIGHT) ? 10'h3FF : 10'h000;
   assign reaction_ms  = r_react;
   assign highscore    = r_hs;
   assign result_valid = (r_state == S_RESULT) && !r_to;
   assign timed_out    = (r_state == S_RESULT) && r_to;
   assign false_start  = (r_state == S_FALSE);
   assign busy         = (r_state == S_ARMED) || (r_state == S_LIGHT);

endmodule
